// File: rtl/sc_datamem_pkg.sv
// Shared types and helpers for the sc_datamem_bx data memory.
// Access sizes, FSM states and the load extension function live here.
package sc_datamem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int IO_BASE_BIT = 31;

    // lane_data arrives right-aligned; only the selected width is kept.
    function automatic logic [31:0] extend(input logic [31:0] lane_data,
                                           input size_t       size,
                                           input logic        sign_ext);
        logic [31:0] result;
        unique case (size)
            SZ_BYTE: result = {{24{sign_ext & lane_data[7]}},  lane_data[7:0]};
            SZ_HALF: result = {{16{sign_ext & lane_data[15]}}, lane_data[15:0]};
            default: result = lane_data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sc_datamem_bank.sv
// Word-organised RAM with four byte write enables and a registered read port,
// shaped for block-RAM inference (single address, read or write per cycle).
module sc_datamem_bank
    import sc_datamem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: the array and read register carry no reset so the tools can map
    // them to block RAM; the parent's clear sequencer zeroes the contents.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sc_datamem_bx.sv
// Byte/half/word data memory with registered read, ready handshake, fault
// detection and post-reset clear. Define SC_DATAMEM_MMIO_EN for the IO region.
module sc_datamem_bx
    import sc_datamem_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int IO_PORTS   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic                     sign_ext,
    input  logic [31:0]              addr,
    input  logic [31:0]              datain,
    output logic [31:0]              dataout,
    output logic                     ready,
    output logic                     busy,
    output logic                     misalign
`ifdef SC_DATAMEM_MMIO_EN
    ,
    input  logic [32*IO_PORTS-1:0]   in_port,
    output logic [32*IO_PORTS-1:0]   out_port
`endif
);

    typedef logic [ADDR_WIDTH-1:0] widx_t;

    state_t      state_q,    state_d;
    widx_t       clr_ptr_q,  clr_ptr_d;
    logic        ready_q,    ready_d;
    logic        misalign_q, misalign_d;
    logic        ld_done_q,  ld_done_d;
    logic        ld_zero_q,  ld_zero_d;
    logic [1:0]  ld_lane_q,  ld_lane_d;
    size_t       ld_size_q,  ld_size_d;
    logic        ld_sext_q,  ld_sext_d;
    logic [31:0] hold_q,     hold_d;
`ifdef SC_DATAMEM_MMIO_EN
    logic                   ld_io_q,     ld_io_d;
    logic [31:0]            io_rdata_q,  io_rdata_d;
    logic [32*IO_PORTS-1:0] out_port_q,  out_port_d;
`endif

    size_t       sz;
    widx_t       widx;
    logic        align_fault;
    logic        io_sel;
    logic        fault;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [3:0]  bank_we;
    logic        bank_re;
    widx_t       bank_addr;
    logic [31:0] bank_wdata;
    logic [31:0] bank_rdata;
    logic [31:0] ld_value;
    logic        unused_addr;

    assign sz   = size_t'(size);
    assign widx = addr[ADDR_WIDTH+1:2];

`ifdef SC_DATAMEM_MMIO_EN
    assign unused_addr = ^addr[IO_BASE_BIT-1:ADDR_WIDTH+2];
`else
    assign unused_addr = ^{addr[IO_BASE_BIT:ADDR_WIDTH+2], 32'(IO_PORTS)};
`endif

    // Alignment check and store lane steering, independent of the target region.
    always_comb begin
        unique case (sz)
            SZ_BYTE: begin
                align_fault = 1'b0;
                st_be       = 4'b0001 << addr[1:0];
                st_wdata    = {4{datain[7:0]}};
            end
            SZ_HALF: begin
                align_fault = addr[0];
                st_be       = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata    = {2{datain[15:0]}};
            end
            SZ_WORD: begin
                align_fault = |addr[1:0];
                st_be       = 4'b1111;
                st_wdata    = datain;
            end
            default: begin
                align_fault = 1'b1;
                st_be       = 4'b0000;
                st_wdata    = datain;
            end
        endcase
    end

`ifdef SC_DATAMEM_MMIO_EN
    assign io_sel = addr[IO_BASE_BIT];
    assign fault  = align_fault
                  | (io_sel & ((sz != SZ_WORD) | (int'(widx) >= IO_PORTS)));
`else
    assign io_sel = 1'b0;
    assign fault  = align_fault;
`endif

    // Load result: zero on fault, IO word, or the extended RAM lane.
    always_comb begin
        ld_value = extend(bank_rdata >> {ld_lane_q, 3'b000}, ld_size_q, ld_sext_q);
`ifdef SC_DATAMEM_MMIO_EN
        if (ld_io_q) begin
            ld_value = io_rdata_q;
        end
`endif
        if (ld_zero_q) begin
            ld_value = '0;
        end
        dataout = ld_done_q ? ld_value : hold_q;
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        ready_d    = 1'b0;
        misalign_d = 1'b0;
        ld_done_d  = 1'b0;
        ld_zero_d  = ld_zero_q;
        ld_lane_d  = ld_lane_q;
        ld_size_d  = ld_size_q;
        ld_sext_d  = ld_sext_q;
        hold_d     = dataout;
        bank_we    = 4'b0000;
        bank_re    = 1'b0;
        bank_addr  = widx;
        bank_wdata = st_wdata;
`ifdef SC_DATAMEM_MMIO_EN
        ld_io_d    = ld_io_q;
        io_rdata_d = io_rdata_q;
        out_port_d = out_port_q;
`endif

        unique case (state_q)
            ST_CLEAR: begin
                bank_we    = 4'b1111;
                bank_addr  = clr_ptr_q;
                bank_wdata = '0;
                clr_ptr_d  = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (req) begin
                    ready_d    = 1'b1;
                    misalign_d = fault;
                    if (we) begin
                        if (!fault && !io_sel) begin
                            bank_we = st_be;
                        end
`ifdef SC_DATAMEM_MMIO_EN
                        for (int p = 0; p < IO_PORTS; p++) begin
                            if (!fault && io_sel && int'(widx) == p) begin
                                out_port_d[32*p +: 32] = datain;
                            end
                        end
`endif
                    end else begin
                        ld_done_d = 1'b1;
                        ld_zero_d = fault;
                        ld_lane_d = addr[1:0];
                        ld_size_d = sz;
                        ld_sext_d = sign_ext;
                        bank_re   = !fault && !io_sel;
`ifdef SC_DATAMEM_MMIO_EN
                        ld_io_d = io_sel;
                        for (int p = 0; p < IO_PORTS; p++) begin
                            if (int'(widx) == p) begin
                                io_rdata_d = in_port[32*p +: 32];
                            end
                        end
`endif
                    end
                end
            end
        endcase

        if (reset) begin
            bank_we = 4'b0000;
            bank_re = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_zero_q  <= 1'b0;
            ld_lane_q  <= 2'b00;
            ld_size_q  <= SZ_WORD;
            ld_sext_q  <= 1'b0;
            hold_q     <= '0;
`ifdef SC_DATAMEM_MMIO_EN
            ld_io_q    <= 1'b0;
            io_rdata_q <= '0;
            out_port_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ready_q    <= ready_d;
            misalign_q <= misalign_d;
            ld_done_q  <= ld_done_d;
            ld_zero_q  <= ld_zero_d;
            ld_lane_q  <= ld_lane_d;
            ld_size_q  <= ld_size_d;
            ld_sext_q  <= ld_sext_d;
            hold_q     <= hold_d;
`ifdef SC_DATAMEM_MMIO_EN
            ld_io_q    <= ld_io_d;
            io_rdata_q <= io_rdata_d;
            out_port_q <= out_port_d;
`endif
        end
    end

    assign ready    = ready_q;
    assign misalign = misalign_q;
    assign busy     = (state_q == ST_CLEAR);
`ifdef SC_DATAMEM_MMIO_EN
    assign out_port = out_port_q;
`endif

    sc_datamem_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clock (clock),
        .we    (bank_we),
        .re    (bank_re),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

endmodule

// File: doc/sc_datamem_bx.md
# sc_datamem_bx

Parametrised successor of the single-cycle data memory for the sc_computer datapath. It adds:
- byte, halfword and word access with sign/zero extension;
- a registered one-cycle read with a ready handshake;
- misalignment detection;
- a post-reset clear sequencer that zeroes the array.

It sits between the ALU/store-data path and the writeback mux, replacing the word-only RAM wrapper.

## Interface
Parameters:
- ADDR_WIDTH, 5, word-address bits; array holds 2**ADDR_WIDTH 32-bit words.
- IO_PORTS, 2, number of 32-bit input and output ports (used only with MMIO, see Configuration).

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled each rising edge
- we  in  1  1 = store, 0 = load; qualified by req
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends
- addr  in  32  byte address
- datain  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- dataout  out  32  load result, extended to 32 bits
- ready  out  1  one-cycle pulse; access completed
- busy  out  1  clear sequence in progress; requests ignored
- misalign  out  1  valid with ready; access faulted
- in_port  in  32*IO_PORTS  MMIO only
- out_port  out  32*IO_PORTS  MMIO only

## Operation
State machine: CLEAR, IDLE.

Reset:
- Reset enters CLEAR with clr_ptr=0.
- Output reset values: dataout=0, ready=0, busy=1, misalign=0, out_port=0.

CLEAR:
- Writes 0 to word clr_ptr each cycle and increments clr_ptr.
- After writing word 2**ADDR_WIDTH-1, goes to IDLE and drops busy.
- req is ignored in CLEAR: no write, no ready.
- Reset asserted mid-CLEAR restarts the sequence at clr_ptr=0.

IDLE, addressing:
- Word index is addr[ADDR_WIDTH+1:2].
- Upper address bits are ignored for the RAM region (aliasing/wrap).
- Lane selected by addr[1:0], little-endian.

IDLE, misalignment:
- Faults on half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- Faulting store: memory unchanged.
- Faulting load: dataout=0.
- Either case: ready=1, misalign=1.

IDLE, stores:
- Byte store writes only lane addr[1:0] from datain[7:0].
- Half store writes lanes {addr[1],0}+{0,1} from datain[15:0].
- Word store writes all lanes.
- Other lanes are preserved (per-byte write enables, no read-modify-write).

IDLE, loads:
- Select the lane(s), then extend per sign_ext.
- Word loads ignore sign_ext.

Back-to-back traffic:
- A request is accepted every cycle, no bubbles.
- A load to the address stored in the previous cycle returns the new data.

## Timing
- Accept on rising edge N when req=1 and state=IDLE.
- ready and misalign valid in cycle N+1; dataout valid in cycle N+1.
- dataout holds its value until the next completed load or reset.
- Store commits at edge N; visible to a load accepted at edge N+1.
- Clear duration: exactly 2**ADDR_WIDTH cycles after reset deasserts; busy falls in the cycle the first request can be accepted.
- ready never asserts while busy=1.

## Configuration
Macro: SC_DATAMEM_MMIO_EN.

Defined:
- addr[31]=1 selects the IO region and never touches RAM.
- Word offset k=addr[ADDR_WIDTH+1:2] addresses port k.
- Loads of k<IO_PORTS return in_port[k] registered.
- Stores of k<IO_PORTS update out_port[k]; only word size is allowed.
- Sub-word IO access or k>=IO_PORTS is a fault: misalign=1, no effect.
- out_port resets to 0; CLEAR does not touch out_port.

Undefined:
- in_port and out_port are absent.
- addr[31] is ignored; all accesses go to RAM.

## Structure
Package sc_datamem_pkg holds:
- enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD};
- enum state_t {ST_CLEAR, ST_IDLE};
- constant IO_BASE_BIT=31;
- function extend(lane_data, size, sign_ext).

One sub-module, sc_datamem_bank: 2**ADDR_WIDTH x 32 array with 4 byte write enables and a registered read, inferable as block RAM. The parent holds the FSM, lane steering, fault logic and MMIO.

## Test plan
- Reset, then idle: busy=1 for exactly 32 cycles (ADDR_WIDTH=5); every load after that returns 0; req during clear gives no ready and no write.
- SW 0x12345678 @0x10, then LB @0x13 sign_ext=1 -> 0x00000012. LH @0x10 -> 0x00005678. SB 0xFF @0x11, then LW @0x10 -> 0x1234FF78. LB @0x11 sign -> 0xFFFFFFFF; zero -> 0x000000FF.
- Back-to-back: SW 0xA5A5A5A5 @0x20 at edge N, LW @0x20 at N+1 -> dataout=0xA5A5A5A5 at N+2 with ready each cycle.
- Misalign: LW @0x02, SH 0xBEEF @0x05, size=11 -> misalign=1, dataout=0; memory at 0x04 unchanged.
- Wrap: SW 0x1 @0x80 with ADDR_WIDTH=5 -> LW @0x00 returns 0x1. Reset asserted mid-clear at cycle 10 -> busy stays 1 for a full 32 cycles after release.
- MMIO (macro on): in_port[1]=0xCAFEF00D, LW @0x80000004 -> 0xCAFEF00D. SW 0x55 @0x80000000 -> out_port[0]=0x55, RAM word 0 unchanged. SB to IO -> misalign=1.
